pid_engine_mc: RTL
==================

# pid_engine_mc

Parametrised, multi-channel successor to the PID datapath: a self-sequenced engine that accepts one measurement per request and returns a saturated duty word after a fixed latency. It holds integrator and previous-error state for NCH independent loops. It uses a sequential radix-2 Booth multiplier and a signed saturating adder. It sits between the sample front end (xmeas source, setpoint/gain config) and the PWM duty register, and replaces the externally-sequenced datapath plus controller pair.

## Interface
- W, 14, signed data width of all operands and results
- FRAC, 12, fractional bits of the gains (gain 1.0 = 2^FRAC)
- NCH, 2, number of independent channels (power of two, ≥1)
- CHW, $clog2(NCH) (min 1), channel index width (derived, not overridden)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_vld  in  1  request valid
- start_rdy  out  1  engine idle, will accept
- ch  in  CHW  channel of request
- xmeas  in  W  signed measurement
- xset  in  W  signed setpoint
- kp, ki, kd  in  W each  signed gains, Q(W-FRAC).FRAC
- clr_int  in  1  clear channel integrator before this sample
- duty  out  W  signed saturated result (holds until next result)
- duty_vld  out  1  one-cycle pulse, duty valid
- duty_ch  out  CHW  channel of duty
- busy  out  1  = ~start_rdy

## Operation
- Accept on a clk edge with start_vld & start_rdy. On that edge, capture all inputs into working registers, clear acc, and go to ERR.
- States: IDLE → ERR → INTEG → DIFF → MUL_P → MUL_I → MUL_D → IDLE.
- ERR: err = sat(xset − xmeas).
- INTEG: sumerr[ch] = sat((clr_int ? 0 : sumerr[ch]) + err).
- DIFF: diferr = sat(err − preverr[ch]); preverr[ch] = err.
- MUL_x: Booth product P = gain × operand, 2W-bit signed, over W iterations (kp×err, ki×sumerr, kd×diferr).
  - On the last iteration: term = sat(P >>> FRAC), with arithmetic shift and truncation toward −∞.
  - Then acc = sat(acc + term).
- sat(): clamp to [−2^(W−1), 2^(W−1)−1], using the sign-overflow rule on operand MSBs. It never wraps.
- Leaving MUL_D: duty = acc, duty_ch = ch, duty_vld = 1 for one cycle.
- If ch ≥ NCH: the request is accepted, the full latency is used, duty = 0 is reported, and no channel state is modified.

## Timing
- Reset values: duty=0, duty_vld=0, duty_ch=0, start_rdy=1, busy=0, state=IDLE, all sumerr/preverr=0.
- Number edges from the accept edge (edge 0):
  - ERR completes at edge 1, INTEG at 2, DIFF at 3.
  - MUL_P occupies edges 4..3+W, MUL_I 4+W..3+2W, MUL_D 4+2W..3+3W.
  - duty/duty_vld update on edge 3+3W, which is 45 for W=14.
- start_rdy is low from edge 0 through edge 3+3W−1. It is high in the duty_vld cycle, so back-to-back requests are allowed with one accept per 3W+3 cycles.
- start_vld while busy is ignored; there is no queueing.
- Inputs are sampled only on the accept edge; later changes have no effect.
- rst mid-operation: on the next edge, return to IDLE and restore all reset values. No duty_vld is produced for the aborted request, and channel state is cleared.
- Channel state updates are committed at edges 2 and 3 even if the result is later aborted by rst. rst clears that state anyway.

## Structure
- pid_pkg: state enum, sat_add/sat_sub functions parametrised on W, and SMAX/SMIN constants.
- Sub-module booth_mult_seq (param W):
  - Inputs: start, multiplicand, multiplier.
  - Outputs: 2W product, done after W cycles.
  - Reused for all three products.
- Top level: FSM, iteration counter, per-channel register arrays, and the result register.

## Test plan
All values use W=14, FRAC=12; 0x1000 = 1.0.
- Reset: assert rst for 2 cycles → duty=0, duty_vld=0, start_rdy=1, busy=0.
- P only: kp=0x1000, ki=kd=0, ch0, xset=1000, xmeas=400 → duty=600, duty_vld exactly at edge 45, duty_ch=0.
- Integrator isolation: ki=0x1000, kp=kd=0, err=100.
  - Three requests on ch0 interleaved with err=−50 on ch1 → ch0 duty 100, 200, 300; ch1 duty −50, −100, −150.
  - Then clr_int=1 on ch0 with err=100 → duty 100.
- Saturation:
  - xset=8191, xmeas=−8192 → err=8191.
  - With kp=0x1FFF → duty=8191.
  - Mirror case (xset=−8192, xmeas=8191) → duty=−8192.
- Derivative sign: kd=0x1000, kp=ki=0, ch0 err=600 then err=0 → second duty=−600 (0x3DA8).
- Handshake/abort:
  - start_vld held during busy → no second accept until the duty_vld cycle.
  - rst at edge 20 → no duty_vld, sumerr[0]=0 on the next request.

Source files
------------

// File: rtl/pid_engine_mc_pkg.sv
// Shared types and saturating arithmetic for the multi-channel PID engine.
//   pid_state_t : engine sequencer states (also exported for debug)
//   smax/smin   : signed range limits for a given width
//   sat/sat_add/sat_sub : clamp to the signed range of width w, never wrap
package pid_engine_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_INTEG,
    S_DIFF,
    S_MUL_P,
    S_MUL_I,
    S_MUL_D
  } pid_state_t;

  function automatic logic signed [63:0] smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Operands are sign-extended into 64 bits, so the exact result is formed
  // first and then clamped; this is equivalent to the operand-MSB overflow rule.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    if (v > smax(w)) return smax(w);
    if (v < smin(w)) return smin(w);
    return v;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    return sat(a + b, w);
  endfunction

  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    return sat(a - b, w);
  endfunction

endpackage

// File: rtl/pid_engine_mc_if.sv
// Request/result bundle of the PID engine.
//   Handshake: a request transfers on the rising clk edge where
//   start_vld & start_rdy are both high; the master holds its fields stable
//   while start_vld is high and the engine samples them only on that edge.
//   duty_vld is a one-cycle pulse with no back-pressure; duty/duty_ch hold
//   until the next result.
//   master : request source (drives start_vld, ch, xmeas, xset, gains, clr_int)
//   slave  : the engine (drives start_rdy, busy, duty, duty_vld, duty_ch)
interface pid_engine_mc_if #(
  parameter int W   = 14,
  parameter int CHW = 1
);
  logic                start_vld;
  logic                start_rdy;
  logic [CHW-1:0]      ch;
  logic signed [W-1:0] xmeas;
  logic signed [W-1:0] xset;
  logic signed [W-1:0] kp;
  logic signed [W-1:0] ki;
  logic signed [W-1:0] kd;
  logic                clr_int;
  logic signed [W-1:0] duty;
  logic                duty_vld;
  logic [CHW-1:0]      duty_ch;
  logic                busy;

  modport master (
    output start_vld, ch, xmeas, xset, kp, ki, kd, clr_int,
    input  start_rdy, busy, duty, duty_vld, duty_ch
  );

  modport slave (
    input  start_vld, ch, xmeas, xset, kp, ki, kd, clr_int,
    output start_rdy, busy, duty, duty_vld, duty_ch
  );
endinterface

// File: rtl/pid_engine_mc_booth.sv
// Sequential radix-2 Booth multiplier, one partial product per clock.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operands (multiplicand is latched internally)
//   mcand    : signed multiplicand (W bits)
//   mplier   : signed multiplier (W bits)
//   product  : signed 2W-bit product, valid while done is high
//   done     : high in the W-th cycle after start; product is the result of
//              the step taken on the next edge, so the caller consumes it on
//              that same edge
module pid_engine_mc_booth #(
  parameter int W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [W-1:0]   mcand,
  input  logic signed [W-1:0]   mplier,
  output logic signed [2*W-1:0] product,
  output logic                  done
);
  localparam int CW = $clog2(W + 1);

  // p = {upper accumulator (W+1 bits), multiplier (W bits), q-1}
  logic [2*W+1:0]      p;
  logic [2*W+1:0]      p_next;
  logic signed [W-1:0] m_r;
  logic [CW-1:0]       cnt;
  logic                run;
  logic signed [W:0]   upper;
  logic signed [W:0]   upper_n;
  logic signed [W:0]   m_ext;

  always_comb begin
    upper   = p[2*W+1:W+1];
    m_ext   = {m_r[W-1], m_r};
    upper_n = upper;
    case (p[1:0])
      2'b01:   upper_n = upper + m_ext;
      2'b10:   upper_n = upper - m_ext;
      default: upper_n = upper;
    endcase
    // arithmetic shift right of {upper_n, multiplier, q-1}
    p_next = {upper_n[W], upper_n, p[W:1]};
  end

  assign product = p_next[2*W:1];
  assign done    = run && (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= '0;
      m_r <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      p   <= {{(W + 1){1'b0}}, mplier, 1'b0};
      m_r <= mcand;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      p   <= p_next;
      cnt <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/pid_engine_mc.sv
// Self-sequenced multi-channel PID engine. One request yields one saturated
// duty word 3W+3 edges after the accept edge. Integrator and previous-error
// state is kept per channel; the three gain products share one Booth unit.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : request/result bundle (slave side)
//   dbg_state : current sequencer state
module pid_engine_mc
  import pid_engine_mc_pkg::*;
#(
  parameter int W    = 14,
  parameter int FRAC = 12,
  parameter int NCH  = 2,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  pid_engine_mc_if.slave   bus,
  output pid_state_t       dbg_state
);
  pid_state_t          state;
  logic                rdy_r;
  logic [CHW-1:0]      ch_r;
  logic signed [W-1:0] xmeas_r, xset_r, kp_r, ki_r, kd_r;
  logic                clr_r;
  logic signed [W-1:0] err_r, sum_r, dif_r, acc;
  logic signed [W-1:0] duty_r;
  logic                duty_vld_r;
  logic [CHW-1:0]      duty_ch_r;
  logic signed [W-1:0] sumerr  [NCH];
  logic signed [W-1:0] preverr [NCH];

  logic                  ch_ok;
  logic signed [W-1:0]   sum_cur, prev_cur;
  logic signed [W-1:0]   err_n, sum_n, dif_n, term, acc_n;
  logic                  m_start, m_done;
  logic signed [W-1:0]   m_cand, m_plier;
  logic signed [2*W-1:0] m_prod;

  // Out-of-range channels run the full sequence but never touch the arrays.
  assign ch_ok    = int'(ch_r) < NCH;
  assign sum_cur  = ch_ok ? sumerr[ch_r]  : '0;
  assign prev_cur = ch_ok ? preverr[ch_r] : '0;

  assign err_n = W'(sat_sub(64'(xset_r), 64'(xmeas_r), W));
  assign sum_n = W'(sat_add(clr_r ? 64'sd0 : 64'(sum_cur), 64'(err_r), W));
  assign dif_n = W'(sat_sub(64'(err_r), 64'(prev_cur), W));
  // >>> on the signed product truncates toward minus infinity
  assign term  = W'(sat(64'(m_prod >>> FRAC), W));
  assign acc_n = W'(sat_add(64'(acc), 64'(term), W));

  // The multiplier for the next term is loaded on the edge that finishes
  // the previous one, so each MUL_x state lasts exactly W edges.
  always_comb begin
    m_start = 1'b0;
    m_cand  = kp_r;
    m_plier = err_r;
    case (state)
      S_DIFF:  m_start = 1'b1;
      S_MUL_P: begin m_start = m_done; m_cand = ki_r; m_plier = sum_r; end
      S_MUL_I: begin m_start = m_done; m_cand = kd_r; m_plier = dif_r; end
      default: m_start = 1'b0;
    endcase
  end

  pid_engine_mc_booth #(.W(W)) u_booth (
    .clk     (clk),
    .rst     (rst),
    .start   (m_start),
    .mcand   (m_cand),
    .mplier  (m_plier),
    .product (m_prod),
    .done    (m_done)
  );

  always_ff @(posedge clk) begin
    duty_vld_r <= 1'b0;
    if (rst) begin
      state     <= S_IDLE;
      rdy_r     <= 1'b1;
      ch_r      <= '0;
      xmeas_r   <= '0;
      xset_r    <= '0;
      kp_r      <= '0;
      ki_r      <= '0;
      kd_r      <= '0;
      clr_r     <= 1'b0;
      err_r     <= '0;
      sum_r     <= '0;
      dif_r     <= '0;
      acc       <= '0;
      duty_r    <= '0;
      duty_ch_r <= '0;
      for (int i = 0; i < NCH; i++) begin
        sumerr[i]  <= '0;
        preverr[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_vld && rdy_r) begin
            ch_r    <= bus.ch;
            xmeas_r <= bus.xmeas;
            xset_r  <= bus.xset;
            kp_r    <= bus.kp;
            ki_r    <= bus.ki;
            kd_r    <= bus.kd;
            clr_r   <= bus.clr_int;
            acc     <= '0;
            rdy_r   <= 1'b0;
            state   <= S_ERR;
          end
        end
        S_ERR: begin
          err_r <= err_n;
          state <= S_INTEG;
        end
        S_INTEG: begin
          sum_r <= sum_n;
          if (ch_ok) sumerr[ch_r] <= sum_n;
          state <= S_DIFF;
        end
        S_DIFF: begin
          dif_r <= dif_n;
          if (ch_ok) preverr[ch_r] <= err_r;
          state <= S_MUL_P;
        end
        S_MUL_P: if (m_done) begin acc <= acc_n; state <= S_MUL_I; end
        S_MUL_I: if (m_done) begin acc <= acc_n; state <= S_MUL_D; end
        S_MUL_D: begin
          if (m_done) begin
            duty_r     <= ch_ok ? acc_n : '0;
            duty_ch_r  <= ch_r;
            duty_vld_r <= 1'b1;
            rdy_r      <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.start_rdy = rdy_r;
  assign bus.busy      = ~rdy_r;
  assign bus.duty      = duty_r;
  assign bus.duty_vld  = duty_vld_r;
  assign bus.duty_ch   = duty_ch_r;
  assign dbg_state     = state;
endmodule
